// File: rtl/phase_pkg.sv
// Shared definitions for the phase sequencer: one-hot phase bit positions and
// the sequencer state encoding.
package phase_pkg;

  localparam int PHASE_W = 5;
  localparam int F_IDX   = 0;
  localparam int R_IDX   = 1;
  localparam int X_IDX   = 2;
  localparam int M_IDX   = 3;
  localparam int W_IDX   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWAIT,
    S_F,
    S_R,
    S_X,
    S_M,
    S_W,
    S_HALTED
  } state_e;

  // IDLE, FWAIT and HALTED drive no phase bit.
  function automatic logic [PHASE_W-1:0] phase_of(input state_e s);
    logic [PHASE_W-1:0] p;
    p = '0;
    case (s)
      S_F:     p[F_IDX] = 1'b1;
      S_R:     p[R_IDX] = 1'b1;
      S_X:     p[X_IDX] = 1'b1;
      S_M:     p[M_IDX] = 1'b1;
      S_W:     p[W_IDX] = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/phase_gen_if.sv
// Control/status bundle between the phase sequencer (slave) and the logic that
// requests execution and observes the phase bus (master).
interface phase_gen_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step_mode;
  logic             imem_ready;
  logic             dmem_busy;
  logic             halt_req;
  logic [4:0]       phase;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output run, step_mode, imem_ready, dmem_busy, halt_req,
    input  phase, busy, halted, instr_cnt, stall_cnt
  );

  modport slave (
    input  run, step_mode, imem_ready, dmem_busy, halt_req,
    output phase, busy, halted, instr_cnt, stall_cnt
  );
endinterface

// File: rtl/phase_gen.sv
// Multi-cycle F/R/X/M/W sequencer with fetch bubbles, M-hold on data memory,
// a sticky halt and debug retire/stall counters. All outputs are registered.
module phase_gen
  import phase_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  phase_gen_if.slave  bus
);

  state_e             state_q, state_d;
  logic               halt_lat_q, halt_lat_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    halt_lat_d  = halt_lat_q;
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = bus.imem_ready ? S_F : S_FWAIT;
      end
      S_FWAIT: begin
        stall_cnt_d = sat_inc(stall_cnt_q);
        if (bus.imem_ready) state_d = S_F;
      end
      S_F: state_d = S_R;
      S_R: state_d = S_X;
      S_X: begin
        state_d = S_M;
        if (bus.halt_req) halt_lat_d = 1'b1;
      end
      S_M: begin
        if (bus.dmem_busy) stall_cnt_d = sat_inc(stall_cnt_q);
        else               state_d     = S_W;
      end
      S_W: begin
        instr_cnt_d = instr_cnt_q + CNT_W'(1);
        // The halting instruction still retires before the sequencer stops.
        if (halt_lat_q)          state_d = S_HALTED;
        else if (bus.step_mode)  state_d = S_IDLE;
        else if (bus.imem_ready) state_d = S_F;
        else                     state_d = S_FWAIT;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge.
    phase_d  = phase_of(state_d);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALTED);
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      halt_lat_q  <= 1'b0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_lat_q  <= halt_lat_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.instr_cnt = instr_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen with narrow (4-bit) counters so that wrap and
// saturation are reachable in a short run.
module tb_phase_gen;
  import phase_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  phase_gen_if #(.CNT_W(CNT_W)) bus ();

  phase_gen #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.run        = 1'b0;
    bus.step_mode  = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_busy  = 1'b0;
    bus.halt_req   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.phase !== 5'b00000) begin n_fail++; $display("FAIL reset_phase got %b want %b", bus.phase, 5'b00000); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    n_cmp++; if (bus.instr_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_instr_cnt got %0d want 0", bus.instr_cnt); end
    n_cmp++; if (bus.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt); end
    tick();
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.phase !== 5'b00000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_hold cyc %0d got phase %b busy %b want 00000 0", i, bus.phase, bus.busy); end
    end
  endtask

  task automatic test_free_run();
    logic [4:0] e;
    logic       f_prev;
    int         consec;
    do_reset();
    bus.imem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    f_prev = 1'b0;
    consec = 0;
    for (int i = 0; i < 16; i++) begin
      e = 5'b00001 << (i % 5);
      n_cmp++; if (bus.phase !== e) begin n_fail++; $display("FAIL free_run_phase cyc %0d got %b want %b", i, bus.phase, e); end
      if (f_prev && bus.phase[F_IDX]) consec++;
      f_prev = bus.phase[F_IDX];
      if (i < 15) tick();
    end
    n_cmp++; if (bus.instr_cnt !== 4'd3) begin n_fail++; $display("FAIL free_run_instr_cnt got %0d want 3", bus.instr_cnt); end
    n_cmp++; if (bus.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL free_run_stall_cnt got %0d want 0", bus.stall_cnt); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL free_run_busy got %b want 1", bus.busy); end
    n_cmp++; if (consec !== 0) begin n_fail++; $display("FAIL free_run_f_consecutive got %0d want 0", consec); end
  endtask

  // Continues from the free-running state left by test_free_run.
  task automatic test_reset_mid_m();
    bit found;
    found = 1'b0;
    bus.dmem_busy = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.phase === 5'b01000) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL mid_m_reach got phase %b want 01000 within 10 cycles", bus.phase); end
    tick();
    n_cmp++; if (bus.phase !== 5'b01000 || bus.stall_cnt !== 4'd1) begin n_fail++; $display("FAIL mid_m_hold got phase %b stall %0d want 01000 1", bus.phase, bus.stall_cnt); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.phase !== 5'b00000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_m_async got phase %b busy %b want 00000 0", bus.phase, bus.busy); end
    n_cmp++; if (bus.instr_cnt !== 4'd0 || bus.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_m_counters got instr %0d stall %0d want 0 0", bus.instr_cnt, bus.stall_cnt); end
    #1;
    rst = 1'b0;
    bus.dmem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.phase !== 5'b00000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_m_idle cyc %0d got phase %b busy %b want 00000 0", i, bus.phase, bus.busy); end
    end
  endtask

  task automatic test_stalls();
    logic [2:0] drv [15];
    logic [4:0] exp_ph [15];
    drv    = '{3'b110, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b010,
               3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b010};
    exp_ph = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000, 5'b00000, 5'b00001,
               5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b10000};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.run        = drv[i][2];
      bus.imem_ready = drv[i][1];
      bus.dmem_busy  = drv[i][0];
      tick();
      n_cmp++; if (bus.phase !== exp_ph[i]) begin n_fail++; $display("FAIL stalls_phase row %0d got %b want %b", i, bus.phase, exp_ph[i]); end
    end
    n_cmp++; if (bus.stall_cnt !== 4'd5) begin n_fail++; $display("FAIL stalls_stall_cnt got %0d want 5", bus.stall_cnt); end
    n_cmp++; if (bus.instr_cnt !== 4'd1) begin n_fail++; $display("FAIL stalls_instr_cnt got %0d want 1", bus.instr_cnt); end
    tick();
    n_cmp++; if (bus.phase !== 5'b00001 || bus.instr_cnt !== 4'd2) begin n_fail++; $display("FAIL stalls_next_f got phase %b instr %0d want 00001 2", bus.phase, bus.instr_cnt); end
  endtask

  task automatic test_step_mode();
    logic [4:0] e;
    do_reset();
    bus.step_mode  = 1'b1;
    bus.imem_ready = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      bus.run = 1'b1;
      tick();
      bus.run = 1'b0;
      for (int i = 0; i < 5; i++) begin
        e = 5'b00001 << i;
        n_cmp++; if (bus.phase !== e) begin n_fail++; $display("FAIL step_phase instr %0d cyc %0d got %b want %b", n, i, bus.phase, e); end
        tick();
      end
      n_cmp++; if (bus.phase !== 5'b00000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL step_idle instr %0d got phase %b busy %b want 00000 0", n, bus.phase, bus.busy); end
      n_cmp++; if (bus.instr_cnt !== 4'(n)) begin n_fail++; $display("FAIL step_instr_cnt got %0d want %0d", bus.instr_cnt, n); end
      tick();
      tick();
      n_cmp++; if (bus.phase !== 5'b00000) begin n_fail++; $display("FAIL step_stay_idle instr %0d got %b want 00000", n, bus.phase); end
    end
    bus.step_mode = 1'b0;
  endtask

  task automatic test_halt();
    logic [4:0] e;
    do_reset();
    bus.imem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int t = 0; t < 20; t++) begin
      e = 5'b00001 << (t % 5);
      n_cmp++; if (bus.phase !== e) begin n_fail++; $display("FAIL halt_phase cyc %0d got %b want %b", t, bus.phase, e); end
      // R and M of instruction 2 must be ignored; X of instruction 4 halts.
      bus.halt_req = (t == 6) || (t == 8) || (t == 17);
      tick();
    end
    bus.halt_req = 1'b0;
    n_cmp++; if (bus.halted !== 1'b1 || bus.phase !== 5'b00000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL halt_state got halted %b phase %b busy %b want 1 00000 0", bus.halted, bus.phase, bus.busy); end
    n_cmp++; if (bus.instr_cnt !== 4'd4) begin n_fail++; $display("FAIL halt_instr_cnt got %0d want 4", bus.instr_cnt); end
    bus.run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.halted !== 1'b1 || bus.phase !== 5'b00000) begin n_fail++; $display("FAIL halt_ignore_run cyc %0d got halted %b phase %b want 1 00000", i, bus.halted, bus.phase); end
    end
    bus.run = 1'b0;
    n_cmp++; if (bus.instr_cnt !== 4'd4) begin n_fail++; $display("FAIL halt_instr_frozen got %0d want 4", bus.instr_cnt); end
  endtask

  task automatic test_counter_limits();
    do_reset();
    bus.imem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int t = 0; t <= 80; t++) begin
      if (t == 75) begin
        n_cmp++; if (bus.instr_cnt !== 4'd15) begin n_fail++; $display("FAIL limit_instr_15 got %0d want 15", bus.instr_cnt); end
      end
      if (t == 80) begin
        n_cmp++; if (bus.instr_cnt !== 4'd0 || bus.phase !== 5'b00001) begin n_fail++; $display("FAIL limit_instr_wrap got instr %0d phase %b want 0 00001", bus.instr_cnt, bus.phase); end
      end
      if (t < 80) tick();
    end
    do_reset();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    n_cmp++; if (bus.phase !== 5'b00000 || bus.busy !== 1'b1 || bus.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL limit_fwait_entry got phase %b busy %b stall %0d want 00000 1 0", bus.phase, bus.busy, bus.stall_cnt); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) begin
        n_cmp++; if (bus.stall_cnt !== 4'd14) begin n_fail++; $display("FAIL limit_stall_14 got %0d want 14", bus.stall_cnt); end
      end
      if (k == 15 || k == 20) begin
        n_cmp++; if (bus.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL limit_stall_sat k %0d got %0d want 15", k, bus.stall_cnt); end
      end
    end
    bus.imem_ready = 1'b1;
    tick();
    n_cmp++; if (bus.phase !== 5'b00001 || bus.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL limit_fwait_exit got phase %b stall %0d want 00001 15", bus.phase, bus.stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_reset_mid_m();
    test_stalls();
    test_step_mode();
    test_halt();
    test_counter_limits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
